// File: rtl/db_pkg.sv
// Shared constants for the key/value DB stage: protocol match values,
// op codes understood by the DB controller, and the byte offsets of the
// header fields that make up a lookup key.
package db_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  IPV4_VIHL     = 8'h45;

  localparam logic [3:0]  OP_LOOKUP     = 4'h1;
  localparam logic [3:0]  OP_INSERT     = 4'h2;

  // Byte offsets from the start of the Ethernet frame (first byte on the wire)
  localparam int OFF_ETHERTYPE = 12;
  localparam int OFF_VIHL      = 14;
  localparam int OFF_PROTO     = 23;
  localparam int OFF_SRC_IP    = 26;
  localparam int OFF_DST_IP    = 30;
  localparam int OFF_UDP_SPORT = 34;
  localparam int OFF_UDP_DPORT = 36;

  // Pick the byte at a frame offset out of the 64-bit beat that carries it
  function automatic logic [7:0] lane_byte(input logic [63:0] data, input int offset);
    return data[(offset % 8) * 8 +: 8];
  endfunction

endpackage

// File: rtl/key_extract.sv
// key_extract: passive Ethernet/IPv4/UDP header parser on a 64-bit
// AXI4-Stream receive tap. Emits a 96-bit lookup key and an op flag as a
// one-cycle pulse one clock after the fifth beat of a qualifying packet.
// Optional statistics counters are enabled with `define KEY_EXTRACT_STATS_EN.
module key_extract
  import db_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          KEY_SIZE   = 96,
  parameter logic [15:0] DNS_PORT   = 16'd53
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [KEY_SIZE-1:0]     out_key,
  output logic [3:0]              out_flag,
  output logic                    out_valid
`ifdef KEY_EXTRACT_STATS_EN
  ,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_keys,
  output logic [31:0]             stat_drops
`endif
);

  typedef enum logic [1:0] {SOP, HDR, SKIP} state_t;

  // Beat index of each captured field within the frame
  localparam logic [2:0] BEAT_ETH   = 3'(OFF_ETHERTYPE / 8);
  localparam logic [2:0] BEAT_PROTO = 3'(OFF_PROTO / 8);
  localparam logic [2:0] BEAT_SRC   = 3'(OFF_SRC_IP / 8);
  localparam logic [2:0] BEAT_UDP   = 3'(OFF_UDP_SPORT / 8);
  localparam logic [2:0] COUNT_MAX  = 3'd5;

  state_t      state, state_next;
  logic [2:0]  count;
  logic        beat;
  logic        qualify;
  logic        emit;
  logic [15:0] ethertype;
  logic [7:0]  vihl;
  logic [7:0]  proto;
  logic [31:0] src_ip;
  logic [15:0] dst_ip_hi;
  logic [15:0] udp_sport;
  logic        keep_unused;

  assign beat        = s_axis_tvalid & s_axis_tready;
  assign keep_unused = ^s_axis_tkeep[DATA_WIDTH/8-1:6];
  assign udp_sport   = {lane_byte(s_axis_tdata, OFF_UDP_SPORT),
                        lane_byte(s_axis_tdata, OFF_UDP_SPORT + 1)};

  // The fifth beat qualifies when the earlier headers describe a plain
  // IPv4/UDP packet and the beat carries both ports and the dst IP tail
  assign qualify = (ethertype == ETH_TYPE_IPV4) && (vihl == IPV4_VIHL) &&
                   (proto == IP_PROTO_UDP) && (s_axis_tkeep[5:0] == 6'h3F);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= SOP;
    else     state <= state_next;
  end

  // Next-state and emit decision; only handshaked beats move the parser
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    case (state)
      SOP: begin
        if (beat && !s_axis_tlast) state_next = HDR;
      end
      HDR: begin
        if (beat) begin
          if (count == BEAT_UDP) begin
            emit       = qualify;
            state_next = s_axis_tlast ? SOP : SKIP;
          end else if (s_axis_tlast) begin
            state_next = SOP;
          end
        end
      end
      SKIP: begin
        if (beat && s_axis_tlast) state_next = SOP;
      end
      default: state_next = SOP;
    endcase
  end

  // Beat index within the packet, saturating once the headers are past
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 3'd0;
    end else if (beat) begin
      if (s_axis_tlast)            count <= 3'd0;
      else if (count != COUNT_MAX) count <= count + 3'd1;
    end
  end

  // Capture header fields from beats 1 to 3 as they go past
  always_ff @(posedge clk) begin
    if (rst) begin
      ethertype <= 16'h0;
      vihl      <= 8'h0;
      proto     <= 8'h0;
      src_ip    <= 32'h0;
      dst_ip_hi <= 16'h0;
    end else if (state == HDR && beat) begin
      if (count == BEAT_ETH) begin
        ethertype <= {lane_byte(s_axis_tdata, OFF_ETHERTYPE),
                      lane_byte(s_axis_tdata, OFF_ETHERTYPE + 1)};
        vihl      <= lane_byte(s_axis_tdata, OFF_VIHL);
      end
      if (count == BEAT_PROTO) begin
        proto <= lane_byte(s_axis_tdata, OFF_PROTO);
      end
      if (count == BEAT_SRC) begin
        src_ip    <= {lane_byte(s_axis_tdata, OFF_SRC_IP),
                      lane_byte(s_axis_tdata, OFF_SRC_IP + 1),
                      lane_byte(s_axis_tdata, OFF_SRC_IP + 2),
                      lane_byte(s_axis_tdata, OFF_SRC_IP + 3)};
        dst_ip_hi <= {lane_byte(s_axis_tdata, OFF_DST_IP),
                      lane_byte(s_axis_tdata, OFF_DST_IP + 1)};
      end
    end
  end

  // Register the key and op flag on emission; they hold until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_key   <= '0;
      out_flag  <= 4'h0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_key  <= {src_ip, dst_ip_hi,
                     lane_byte(s_axis_tdata, OFF_DST_IP + 2),
                     lane_byte(s_axis_tdata, OFF_DST_IP + 3),
                     lane_byte(s_axis_tdata, OFF_UDP_DPORT),
                     lane_byte(s_axis_tdata, OFF_UDP_DPORT + 1),
                     16'h0};
        out_flag <= (udp_sport == DNS_PORT) ? OP_INSERT : OP_LOOKUP;
      end
    end
  end

`ifdef KEY_EXTRACT_STATS_EN
  logic pkt_keyed;

  // Packet, key and drop counters; a drop is a packet end with no key
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts  <= 32'h0;
      stat_keys  <= 32'h0;
      stat_drops <= 32'h0;
      pkt_keyed  <= 1'b0;
    end else begin
      if (out_valid) stat_keys <= stat_keys + 32'h1;
      if (beat && s_axis_tlast) begin
        stat_pkts <= stat_pkts + 32'h1;
        if (!(pkt_keyed || emit)) stat_drops <= stat_drops + 32'h1;
        pkt_keyed <= 1'b0;
      end else if (emit) begin
        pkt_keyed <= 1'b1;
      end
    end
  end
`endif

endmodule
